// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
// Arbitrates NCACHE cache controllers plus one memory controller onto a
// single registered snoop bus. An owner keeps the bus while it stays active,
// up to MAX_HOLD consecutive cycles when others are waiting; a forced release
// pulses hold_timeout. Memory always has the lowest priority.
// Optional feature macro: SNOOP_BUS_RR_EN -- round-robin among the caches
// (rr_ptr). When undefined, caches use fixed priority with cache 0 highest.
module snoop_bus_arbiter #(
  parameter int NCACHE   = 3,
  parameter int MSG_W    = 11,
  parameter int WB_BIT   = 7,
  parameter int TYPE_LO  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NCACHE*MSG_W-1:0]   cache_msg,
  input  logic [MSG_W-1:0]          mem_msg,
  output logic [MSG_W-1:0]          bus_wire,
  output logic [NCACHE:0]           grant,
  output logic                      bus_busy,
  output logic [ID_W-1:0]           owner_id,
  output logic                      hold_timeout
);

  localparam int NREQ = NCACHE + 1;
  localparam int HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  // Registered state
  logic [0:0]       state_q,        state_d;
  logic [MSG_W-1:0] bus_wire_q,     bus_wire_d;
  logic [NCACHE:0]  grant_q,        grant_d;
  logic             bus_busy_q,     bus_busy_d;
  logic [ID_W-1:0]  owner_id_q,     owner_id_d;
  logic             hold_timeout_q, hold_timeout_d;
  logic [HC_W-1:0]  hold_cnt_q,     hold_cnt_d;

`ifdef SNOOP_BUS_RR_EN
  localparam int RR_W = $clog2(NCACHE);
  logic [RR_W-1:0]  rr_ptr_q,       rr_ptr_d;
  int               rr_idx;
`endif

  // Combinational helpers
  logic [MSG_W-1:0] msg_arr [NREQ];
  logic [NCACHE:0]  req;
  logic [NCACHE:0]  others;
  logic [NCACHE:0]  cand;
  logic             owner_act;
  logic             timeout_fire;
  logic             hold_path;
  logic             win_vld;
  logic [ID_W-1:0]  win_idx;

  // Unpack messages and qualify each requester as active
  always_comb begin
    for (int i = 0; i < NCACHE; i++) begin
      msg_arr[i] = cache_msg[i*MSG_W +: MSG_W];
      req[i]     = cache_msg[i*MSG_W + WB_BIT] |
                   (cache_msg[i*MSG_W + TYPE_LO +: 2] != 2'b00);
    end
    msg_arr[NCACHE] = mem_msg;
    // Memory's write-back flag carries no request meaning
    req[NCACHE]     = (mem_msg[TYPE_LO +: 2] != 2'b00);
  end

  // Decide between holding the current owner and re-arbitrating
  always_comb begin
    owner_act    = (state_q == ST_OWNED) && req[owner_id_q];
    others       = req;
    others[owner_id_q] = 1'b0;
    timeout_fire = (MAX_HOLD != 0) && owner_act &&
                   (hold_cnt_q == HOLD_LAST) && (|others);
    hold_path    = owner_act && !timeout_fire;
    // A forced release excludes the owner; a voluntary one has it inactive anyway
    cand         = timeout_fire ? others : req;
  end

  // Pick the winner among the candidates; memory is only taken if no cache is
`ifdef SNOOP_BUS_RR_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_idx  = 0;
    if (cand[NCACHE]) begin
      win_vld = 1'b1;
      win_idx = ID_W'(NCACHE);
    end
    // Walk backwards so the cache closest to rr_ptr is the last to overwrite
    for (int k = NCACHE - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NCACHE) rr_idx = rr_idx - NCACHE;
      if (cand[rr_idx]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(rr_idx);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    // Descending scan: the lowest active index ends up winning
    for (int i = NCACHE; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(i);
      end
    end
  end
`endif

  // Next-state computation for ownership, bus contents and hold counter
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one unassigned (no latches).
    state_d        = state_q;
    bus_wire_d     = bus_wire_q;
    grant_d        = grant_q;
    owner_id_d     = owner_id_q;
    hold_cnt_d     = hold_cnt_q;
    hold_timeout_d = timeout_fire;
`ifdef SNOOP_BUS_RR_EN
    rr_ptr_d       = rr_ptr_q;
`endif
    if (hold_path) begin
      // Owner keeps the bus; its message may change every cycle
      bus_wire_d = msg_arr[owner_id_q];
      if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
    end else if (win_vld) begin
      state_d    = ST_OWNED;
      grant_d    = NREQ'(1) << win_idx;
      owner_id_d = win_idx;
      hold_cnt_d = '0;
      bus_wire_d = msg_arr[win_idx];
`ifdef SNOOP_BUS_RR_EN
      if (int'(win_idx) < NCACHE) begin
        rr_ptr_d = (int'(win_idx) == NCACHE - 1) ? '0 : RR_W'(int'(win_idx) + 1);
      end
`endif
    end else begin
      // Nobody wants the bus; owner_id deliberately keeps its last value
      state_d    = ST_IDLE;
      grant_d    = '0;
      hold_cnt_d = '0;
      bus_wire_d = '0;
    end
    bus_busy_d = |grant_d;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      bus_wire_q     <= '0;
      grant_q        <= '0;
      bus_busy_q     <= 1'b0;
      owner_id_q     <= '0;
      hold_timeout_q <= 1'b0;
      hold_cnt_q     <= '0;
`ifdef SNOOP_BUS_RR_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q        <= state_d;
      bus_wire_q     <= bus_wire_d;
      grant_q        <= grant_d;
      bus_busy_q     <= bus_busy_d;
      owner_id_q     <= owner_id_d;
      hold_timeout_q <= hold_timeout_d;
      hold_cnt_q     <= hold_cnt_d;
`ifdef SNOOP_BUS_RR_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
    end
  end

  assign bus_wire     = bus_wire_q;
  assign grant        = grant_q;
  assign bus_busy     = bus_busy_q;
  assign owner_id     = owner_id_q;
  assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter
// Directed bench for snoop_bus_arbiter with default parameters
// (NCACHE=3, MSG_W=11, WB_BIT=7, type field [5:4], MAX_HOLD=8).
// Expected round-robin behaviour is selected with SNOOP_BUS_RR_EN.
module tb_snoop_bus_arbiter;

  localparam int NCACHE = 3;
  localparam int MSG_W  = 11;
  localparam int ID_W   = 2;

  logic                    clock;
  logic                    resetn;
  logic [NCACHE*MSG_W-1:0] cache_msg;
  logic [MSG_W-1:0]        mem_msg;
  logic [MSG_W-1:0]        bus_wire;
  logic [NCACHE:0]         grant;
  logic                    bus_busy;
  logic [ID_W-1:0]         owner_id;
  logic                    hold_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  snoop_bus_arbiter dut (
    .clock        (clock),
    .resetn       (resetn),
    .cache_msg    (cache_msg),
    .mem_msg      (mem_msg),
    .bus_wire     (bus_wire),
    .grant        (grant),
    .bus_busy     (bus_busy),
    .owner_id     (owner_id),
    .hold_timeout (hold_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_msgs(input logic [10:0] c0, input logic [10:0] c1,
                          input logic [10:0] c2, input logic [10:0] m);
    cache_msg = {c2, c1, c0};
    mem_msg   = m;
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Short reset pulse placed between clock edges
  task automatic pulse_reset();
    set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [10:0] w,
                            input logic [1:0] id, input logic busy, input logic to);
    check({tag, ".grant"},    32'(grant),        32'(g));
    check({tag, ".bus_wire"}, 32'(bus_wire),     32'(w));
    check({tag, ".owner_id"}, 32'(owner_id),     32'(id));
    check({tag, ".bus_busy"}, 32'(bus_busy),     32'(busy));
    check({tag, ".timeout"},  32'(hold_timeout), 32'(to));
  endtask

  logic [1:0] rr_exp [6];

  initial begin
    resetn = 1'b0;
    set_msgs(11'h0, 11'h013, 11'h0, 11'h0);

    // 1: outputs stay clear while reset is held, even across edges
    #3;
    check_outs("rst_hold", 4'b0000, 11'h0, 2'd0, 1'b0, 1'b0);
    tick();
    check_outs("rst_edge", 4'b0000, 11'h0, 2'd0, 1'b0, 1'b0);
    #2 resetn = 1'b1;
    tick();
    check_outs("t1_grant_c1", 4'b0010, 11'h013, 2'd1, 1'b1, 1'b0);
    set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
    tick();
    check_outs("t1_idle", 4'b0000, 11'h0, 2'd1, 1'b0, 1'b0);

    // 2: simultaneous caches 0 and 2, back-to-back handover
    pulse_reset();
    set_msgs(11'h021, 11'h0, 11'h032, 11'h0);
    tick();
    check_outs("t2_c0_win", 4'b0001, 11'h021, 2'd0, 1'b1, 1'b0);
    set_msgs(11'h025, 11'h0, 11'h032, 11'h0);
    tick();
    check_outs("t2_c0_hold1", 4'b0001, 11'h025, 2'd0, 1'b1, 1'b0);
    tick();
    check_outs("t2_c0_hold2", 4'b0001, 11'h025, 2'd0, 1'b1, 1'b0);
    set_msgs(11'h0, 11'h0, 11'h032, 11'h0);
    tick();
    check_outs("t2_c2_next", 4'b0100, 11'h032, 2'd2, 1'b1, 1'b0);
    set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
    tick();
    check_outs("t2_idle", 4'b0000, 11'h0, 2'd2, 1'b0, 1'b0);

    // 3a: hold timeout with memory waiting
    pulse_reset();
    set_msgs(11'h010, 11'h0, 11'h0, 11'h030);
    tick();
    check_outs("t3_c0_win", 4'b0001, 11'h010, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_outs($sformatf("t3_hold%0d", i), 4'b0001, 11'h010, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check_outs("t3_timeout", 4'b1000, 11'h030, 2'd3, 1'b1, 1'b1);
    tick();
    check_outs("t3_after", 4'b1000, 11'h030, 2'd3, 1'b1, 1'b0);
    set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
    tick();
    check_outs("t3_idle", 4'b0000, 11'h0, 2'd3, 1'b0, 1'b0);

    // 3b: no contender, owner keeps the bus with no pulse
    pulse_reset();
    set_msgs(11'h010, 11'h0, 11'h0, 11'h0);
    tick();
    check_outs("t3b_win", 4'b0001, 11'h010, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check({"t3b_keep.grant"},  32'(grant),        32'h1);
      check({"t3b_keep.pulse"},  32'(hold_timeout), 32'h0);
    end
    set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
    tick();
    check_outs("t3b_idle", 4'b0000, 11'h0, 2'd0, 1'b0, 1'b0);

    // 4: write-back flag qualifies caches but not memory
    pulse_reset();
    set_msgs(11'h0, 11'h0, 11'h0, 11'h080);
    tick();
    check_outs("t4_mem_wb", 4'b0000, 11'h0, 2'd0, 1'b0, 1'b0);
    set_msgs(11'h0, 11'h080, 11'h0, 11'h080);
    tick();
    check_outs("t4_c1_wb", 4'b0010, 11'h080, 2'd1, 1'b1, 1'b0);

    // 5: pulsed requests from all caches
`ifdef SNOOP_BUS_RR_EN
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      set_msgs(11'h010, 11'h010, 11'h010, 11'h0);
      tick();
      check($sformatf("t5_owner%0d", i), 32'(owner_id), 32'(rr_exp[i]));
      check($sformatf("t5_grant%0d", i), 32'(grant),    32'(4'b0001 << rr_exp[i]));
      set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
      tick();
      check($sformatf("t5_gap%0d", i),   32'(bus_busy), 32'h0);
    end

    // 6: asynchronous reset while cache 2 owns the bus
    pulse_reset();
    set_msgs(11'h0, 11'h0, 11'h030, 11'h0);
    tick();
    check_outs("t6_c2_win", 4'b0100, 11'h030, 2'd2, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_outs("t6_async", 4'b0000, 11'h0, 2'd0, 1'b0, 1'b0);
    set_msgs(11'h0, 11'h0, 11'h0, 11'h0);
    #1 resetn = 1'b1;
    tick();
    check_outs("t6_no_replay", 4'b0000, 11'h0, 2'd0, 1'b0, 1'b0);
    set_msgs(11'h0, 11'h0, 11'h031, 11'h0);
    tick();
    check_outs("t6_rearb", 4'b0100, 11'h031, 2'd2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
